// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
// Hold-timeout width helper is used only when HOLD_TIMEOUT_EN is defined.
package rr_grant_scheduler_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Bits needed to count 0..max_hold-1
   function automatic int unsigned hold_cnt_w(input int unsigned max_hold);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(max_hold)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bus between the requesters and the round-robin scheduler.
// master: scheduler side, slave: requester side.
interface rr_grant_scheduler_if;
   import rr_grant_scheduler_pkg::*;

   logic [NUM_REQ-1:0] Req_in;
   logic [NUM_REQ-1:0] Grant_out;
   logic [IDX_W-1:0]   Grant_idx;
   logic               Grant_vld;

   modport master (
      input  Req_in,
      output Grant_out,
      output Grant_idx,
      output Grant_vld
   );

   modport slave (
      output Req_in,
      input  Grant_out,
      input  Grant_idx,
      input  Grant_vld
   );

endinterface

// File: rtl/rr_grant_scheduler_idx_decoder.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero when disabled.
module idx_decoder_3to8
   import rr_grant_scheduler_pkg::*;
(
   input  logic [IDX_W-1:0]   i_idx,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot = NUM_REQ'(1) << i_idx;
      end
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler granting one of eight requesters, held until release.
// Optional hold timeout compiled in with `define HOLD_TIMEOUT_EN.
module rr_grant_scheduler
   import rr_grant_scheduler_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_grant_scheduler_if.master bus
);

   if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
      $error("MAX_HOLD must be within 2..256");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               r_vld;
   logic               w_vld_nxt;
   logic               w_found;
   logic [IDX_W-1:0]   w_winner;
   logic [NUM_REQ-1:0] w_onehot;

`ifdef HOLD_TIMEOUT_EN
   localparam int unsigned CNT_W = hold_cnt_w(MAX_HOLD);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
`endif

   // Rotating priority search: first set request at or above ptr, wrapping 7->0
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!w_found && bus.Req_in[IDX_W'(r_ptr + IDX_W'(i))]) begin
            w_found  = 1'b1;
            w_winner = IDX_W'(r_ptr + IDX_W'(i));
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_vld_nxt   = r_vld;
`ifdef HOLD_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         IDLE: begin
`ifdef HOLD_TIMEOUT_EN
            w_cnt_nxt = '0;
`endif
            if (w_found) begin
               w_idx_nxt   = w_winner;
               w_vld_nxt   = 1'b1;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!bus.Req_in[r_idx]) begin
               w_vld_nxt   = 1'b0;
               w_idx_nxt   = '0;
               w_ptr_nxt   = IDX_W'(r_idx + IDX_W'(1));
               w_state_nxt = IDLE;
`ifdef HOLD_TIMEOUT_EN
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_W'(MAX_HOLD - 1)) begin
               // Owner overstayed: revoke and move priority past it
               w_vld_nxt   = 1'b0;
               w_idx_nxt   = '0;
               w_ptr_nxt   = IDX_W'(r_idx + IDX_W'(1));
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = CNT_W'(r_cnt + CNT_W'(1));
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_vld   <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_vld   <= w_vld_nxt;
`ifdef HOLD_TIMEOUT_EN
         r_cnt   <= w_cnt_nxt;
`endif
      end
   end

   idx_decoder_3to8 u_dec (
      .i_idx    (r_idx),
      .i_en     (r_vld),
      .o_onehot (w_onehot)
   );

   assign bus.Grant_out = w_onehot;
   assign bus.Grant_idx = r_idx;
   assign bus.Grant_vld = r_vld;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler.
// Build with HOLD_TIMEOUT_EN defined to exercise the hold timeout (MAX_HOLD=4).
module tb_rr_grant_scheduler;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   rr_grant_scheduler_if bus_if ();

   rr_grant_scheduler #(.MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_if.Req_in = 8'h00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus_if.Grant_vld !== 1'b0) begin
         n_fail++; $display("FAIL reset_vld: got %b expected 0", bus_if.Grant_vld);
      end
      n_checks++;
      if (bus_if.Grant_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_out: got %h expected 00", bus_if.Grant_out);
      end
      n_checks++;
      if (bus_if.Grant_idx !== 3'd0) begin
         n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus_if.Grant_idx);
      end
      // Grant requester 3, then reset asynchronously mid-grant
      bus_if.Req_in = 8'h08;
      tick();
      n_checks++;
      if (bus_if.Grant_out !== 8'h08) begin
         n_fail++; $display("FAIL pre_reset_grant: got %h expected 08", bus_if.Grant_out);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus_if.Grant_out !== 8'h00) begin
         n_fail++; $display("FAIL async_reset_out: got %h expected 00", bus_if.Grant_out);
      end
      n_checks++;
      if (bus_if.Grant_vld !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_vld: got %b expected 0", bus_if.Grant_vld);
      end
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd3 || bus_if.Grant_vld !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_grant: got idx %0d vld %b expected idx 3 vld 1",
                            bus_if.Grant_idx, bus_if.Grant_vld);
      end
      bus_if.Req_in = 8'h00;
      tick();
   endtask

   task automatic test_rotation();
      logic [2:0] owner;
      do_reset();
      bus_if.Req_in = 8'hFF;
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd0 || bus_if.Grant_out !== 8'h01) begin
         n_fail++; $display("FAIL rot_first: got idx %0d out %h expected idx 0 out 01",
                            bus_if.Grant_idx, bus_if.Grant_out);
      end
      owner = 3'd0;
      for (int k = 0; k < 8; k++) begin
         bus_if.Req_in = 8'hFF & ~(8'h01 << owner);
         tick();
         n_checks++;
         if (bus_if.Grant_vld !== 1'b0) begin
            n_fail++; $display("FAIL rot_idle_%0d: got vld %b expected 0", k, bus_if.Grant_vld);
         end
         bus_if.Req_in = 8'hFF;
         tick();
         owner = owner + 3'd1;
         n_checks++;
         if (bus_if.Grant_idx !== owner || bus_if.Grant_out !== (8'h01 << owner)) begin
            n_fail++; $display("FAIL rot_grant_%0d: got idx %0d out %h expected idx %0d",
                               k, bus_if.Grant_idx, bus_if.Grant_out, owner);
         end
      end
      bus_if.Req_in = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_priority();
      // Serve 5 so ptr=6, then 1:0 requested -> wrap to 0
      do_reset();
      bus_if.Req_in = 8'h20;
      tick();
      bus_if.Req_in = 8'h00;
      tick();
      bus_if.Req_in = 8'h03;
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd0 || bus_if.Grant_out !== 8'h01) begin
         n_fail++; $display("FAIL wrap_prio: got idx %0d out %h expected idx 0 out 01",
                            bus_if.Grant_idx, bus_if.Grant_out);
      end
      // Serve 4 so ptr=5, then 5 and 0 requested -> 5 wins
      do_reset();
      bus_if.Req_in = 8'h10;
      tick();
      bus_if.Req_in = 8'h00;
      tick();
      bus_if.Req_in = 8'h21;
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd5 || bus_if.Grant_out !== 8'h20) begin
         n_fail++; $display("FAIL ptr5_prio: got idx %0d out %h expected idx 5 out 20",
                            bus_if.Grant_idx, bus_if.Grant_out);
      end
      bus_if.Req_in = 8'h00;
      tick();
   endtask

   task automatic test_no_requests();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         tick();
         n_checks++;
         if (bus_if.Grant_vld !== 1'b0 || bus_if.Grant_out !== 8'h00 ||
             bus_if.Grant_idx !== 3'd0) begin
            n_fail++; $display("FAIL idle_%0d: got vld %b out %h idx %0d expected all zero",
                               k, bus_if.Grant_vld, bus_if.Grant_out, bus_if.Grant_idx);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus_if.Req_in = 8'h04;
      tick();
      // Non-owners raised during the grant must not disturb it
      bus_if.Req_in = 8'h0E;
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd2 || bus_if.Grant_out !== 8'h04) begin
         n_fail++; $display("FAIL hold_owner: got idx %0d out %h expected idx 2 out 04",
                            bus_if.Grant_idx, bus_if.Grant_out);
      end
      bus_if.Req_in = 8'h10;
      tick();
      n_checks++;
      if (bus_if.Grant_vld !== 1'b0) begin
         n_fail++; $display("FAIL handoff_gap: got vld %b expected 0", bus_if.Grant_vld);
      end
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd4 || bus_if.Grant_vld !== 1'b1 ||
          bus_if.Grant_out !== 8'h10) begin
         n_fail++; $display("FAIL handoff_grant: got idx %0d vld %b out %h expected idx 4 vld 1 out 10",
                            bus_if.Grant_idx, bus_if.Grant_vld, bus_if.Grant_out);
      end
      bus_if.Req_in = 8'h00;
      tick();
   endtask

`ifdef HOLD_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      bus_if.Req_in = 8'h03;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (bus_if.Grant_idx !== 3'd0 || bus_if.Grant_vld !== 1'b1) begin
            n_fail++; $display("FAIL to_hold_%0d: got idx %0d vld %b expected idx 0 vld 1",
                               k, bus_if.Grant_idx, bus_if.Grant_vld);
         end
      end
      tick();
      n_checks++;
      if (bus_if.Grant_vld !== 1'b0) begin
         n_fail++; $display("FAIL to_revoke: got vld %b expected 0", bus_if.Grant_vld);
      end
      tick();
      n_checks++;
      if (bus_if.Grant_idx !== 3'd1 || bus_if.Grant_vld !== 1'b1) begin
         n_fail++; $display("FAIL to_next: got idx %0d vld %b expected idx 1 vld 1",
                            bus_if.Grant_idx, bus_if.Grant_vld);
      end
      bus_if.Req_in = 8'h00;
      tick();
   endtask
`else
   task automatic test_hold();
      do_reset();
      bus_if.Req_in = 8'h03;
      tick();
      for (int k = 0; k < 30; k++) begin
         tick();
         n_checks++;
         if (bus_if.Grant_idx !== 3'd0 || bus_if.Grant_vld !== 1'b1) begin
            n_fail++; $display("FAIL hold_%0d: got idx %0d vld %b expected idx 0 vld 1",
                               k, bus_if.Grant_idx, bus_if.Grant_vld);
         end
      end
      bus_if.Req_in = 8'h00;
      tick();
   endtask
`endif

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus_if.Req_in = 8'h00;
      test_reset();
      test_rotation();
      test_priority();
      test_no_requests();
      test_back_to_back();
`ifdef HOLD_TIMEOUT_EN
      test_timeout();
`else
      test_hold();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
